// File: rtl/breakout_ctrl.sv
`timescale 1ns/1ps
// Breakout game sequencer: paddle/ball/lives/score state, stepped once per frame_tick.
// Keypad rising edges move the paddle or serve; ball position is registered except in IDLE.
module breakout_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_Y    = 440,
  parameter int BALL_R      = 4,
  parameter int BALL_SPEED  = 2,
  parameter int PADDLE_STEP = 16,
  parameter int LIVES       = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frame_tick,
  input  logic [4:0] key_code,
  input  logic       key_ready,
  output logic [9:0] paddle_x,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [1:0] state,
  output logic       miss
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  localparam logic [9:0] PAD_MAX    = 10'(H_RES - PADDLE_W);
  localparam logic [9:0] PAD_RST    = 10'((H_RES - PADDLE_W) / 2);
  localparam logic [9:0] STEP       = 10'(PADDLE_STEP);
  localparam logic [9:0] HALF_W     = 10'(PADDLE_W / 2);
  localparam logic [8:0] REST_Y     = 9'(PADDLE_Y - BALL_R - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic signed [10:0] SPD    = 11'(BALL_SPEED);
  localparam logic signed [10:0] X_LO   = 11'(BALL_R);
  localparam logic signed [10:0] X_HI   = 11'(H_RES - 1 - BALL_R);
  localparam logic signed [10:0] Y_LO   = 11'(BALL_R);
  localparam logic signed [10:0] Y_HIT  = 11'(PADDLE_Y - BALL_R);
  localparam logic signed [10:0] Y_MISS = 11'(V_RES - 1 - BALL_R);
  localparam logic signed [10:0] PW1    = 11'(PADDLE_W - 1);

  state_t      st, st_n;
  logic [9:0]  pad, pad_n, bx, bx_n;
  logic [8:0]  by, by_n;
  logic        dx, dx_n, dy, dy_n;     // 1 = positive direction
  logic [1:0]  lv, lv_n;
  logic [7:0]  sc, sc_n;
  logic        miss_q, miss_n, key_q;
  logic        key_ev, go_left, go_right, go_serve;
  logic signed [10:0] nx, ny, pad_lo, pad_hi;

  assign key_ev   = key_ready & ~key_q;
  assign go_left  = key_ev && (key_code == 5'h0c);
  assign go_right = key_ev && (key_code == 5'h0e);
  assign go_serve = key_ev && (key_code == 5'h10);

  always_comb begin
    st_n   = st;
    pad_n  = pad;
    bx_n   = bx;
    by_n   = by;
    dx_n   = dx;
    dy_n   = dy;
    lv_n   = lv;
    sc_n   = sc;
    miss_n = 1'b0;
    nx     = $signed({1'b0, bx}) + (dx ? SPD : -SPD);
    ny     = $signed({2'b0, by}) + (dy ? SPD : -SPD);
    pad_lo = $signed({1'b0, pad});
    pad_hi = pad_lo + PW1;

    // Paddle check below reads the pre-move register, so moving here is safe.
    if (st != OVER) begin
      if (go_left)       pad_n = (pad < STEP) ? '0 : pad - STEP;
      else if (go_right) pad_n = (pad > PAD_MAX - STEP) ? PAD_MAX : pad + STEP;
    end

    unique case (st)
      IDLE: if (go_serve) begin
        st_n = PLAY;
        dx_n = 1'b1;
        dy_n = 1'b0;
        bx_n = pad + HALF_W;
        by_n = REST_Y;
      end
      PLAY: if (frame_tick) begin
        if (nx <= X_LO) begin
          nx   = X_LO;
          dx_n = 1'b1;
        end else if (nx >= X_HI) begin
          nx   = X_HI;
          dx_n = 1'b0;
        end
        if (ny <= Y_LO) begin
          ny   = Y_LO;
          dy_n = 1'b1;
        end
        if (dy && ny >= Y_HIT && $signed({2'b0, by}) < Y_HIT && nx >= pad_lo && nx <= pad_hi) begin
          ny   = Y_HIT;
          dy_n = 1'b0;
          if (sc != 8'hff) sc_n = sc + 8'd1;
        end
        if (ny >= Y_MISS) begin
          miss_n = 1'b1;
          lv_n   = lv - 2'd1;
          st_n   = (lv == 2'd1) ? OVER : IDLE;
        end
        bx_n = nx[9:0];
        by_n = ny[8:0];
      end
      OVER: if (go_serve) begin
        lv_n  = LIVES_INIT;
        sc_n  = '0;
        pad_n = PAD_RST;
        st_n  = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st     <= IDLE;
      pad    <= PAD_RST;
      bx     <= PAD_RST + HALF_W;
      by     <= REST_Y;
      dx     <= 1'b1;
      dy     <= 1'b0;
      lv     <= LIVES_INIT;
      sc     <= '0;
      miss_q <= 1'b0;
      key_q  <= 1'b0;
    end else begin
      st     <= st_n;
      pad    <= pad_n;
      bx     <= bx_n;
      by     <= by_n;
      dx     <= dx_n;
      dy     <= dy_n;
      lv     <= lv_n;
      sc     <= sc_n;
      miss_q <= miss_n;
      key_q  <= key_ready;
    end
  end

  // In IDLE the ball sits on the paddle, so it follows paddle_x on the same edge.
  assign paddle_x = pad;
  assign ball_x   = (st == IDLE) ? pad + HALF_W : bx;
  assign ball_y   = (st == IDLE) ? REST_Y : by;
  assign lives    = lv;
  assign score    = sc;
  assign state    = st;
  assign miss     = miss_q;
endmodule

// File: tb/tb_breakout_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for breakout_ctrl: vector table, hand-built game sequences,
// and a random phase, all compared against an integer game model every cycle.
module tb_breakout_ctrl;
  logic       clk = 1'b0, rstn = 1'b0, frame_tick = 1'b0, key_ready = 1'b0;
  logic [4:0] key_code = 5'h00;
  logic [9:0] paddle_x, ball_x;
  logic [8:0] ball_y;
  logic [1:0] lives, state;
  logic [7:0] score;
  logic       miss;

  breakout_ctrl dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .key_code(key_code), .key_ready(key_ready),
    .paddle_x(paddle_x), .ball_x(ball_x), .ball_y(ball_y), .lives(lives), .score(score),
    .state(state), .miss(miss)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_pad, m_bx, m_by, m_dx, m_dy, m_lives, m_score, m_st, m_miss;
  bit m_kq;
  int miss_cnt, max_bx, guard;
  bit rnd_kr;
  logic [4:0] rnd_kc;

  typedef struct { logic [4:0] code; int exp_pad; int exp_bx; } vec_t;
  vec_t tbl [24];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pad = 288; m_bx = 320; m_by = 435; m_dx = 1; m_dy = -1;
    m_lives = 3; m_score = 0; m_st = 0; m_miss = 0; m_kq = 1'b0;
  endtask

  // Game rules in plain integer arithmetic; one call per clock edge.
  task automatic model_update(input bit kr, input logic [4:0] kc, input bit ft);
    bit ev;
    int old_pad, nx, ny;
    ev = kr && !m_kq;
    m_kq = kr;
    m_miss = 0;
    old_pad = m_pad;
    if (ev && m_st != 2) begin
      if (kc == 5'h0c) m_pad = (m_pad >= 16) ? m_pad - 16 : 0;
      else if (kc == 5'h0e) m_pad = (m_pad + 16 > 576) ? 576 : m_pad + 16;
    end
    if (m_st == 0) begin
      if (ev && kc == 5'h10) begin
        m_st = 1; m_bx = old_pad + 32; m_by = 435; m_dx = 1; m_dy = -1;
      end
    end else if (m_st == 1) begin
      if (ft) begin
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        if (nx <= 4) begin nx = 4; m_dx = 1; end
        else if (nx >= 635) begin nx = 635; m_dx = -1; end
        if (ny <= 4) begin ny = 4; m_dy = 1; end
        if (m_dy == 1 && ny >= 436 && m_by < 436 && nx >= old_pad && nx <= old_pad + 63) begin
          ny = 436; m_dy = -1;
          if (m_score < 255) m_score++;
        end
        if (ny >= 475) begin
          m_miss = 1; m_lives--;
          m_st = (m_lives == 0) ? 2 : 0;
        end
        m_bx = nx; m_by = ny;
      end
    end else begin
      if (ev && kc == 5'h10) begin
        m_lives = 3; m_score = 0; m_pad = 288; m_st = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("paddle_x", int'(paddle_x), m_pad);
    chk("ball_x", int'(ball_x), (m_st == 0) ? m_pad + 32 : m_bx);
    chk("ball_y", int'(ball_y), (m_st == 0) ? 435 : m_by);
    chk("lives", int'(lives), m_lives);
    chk("score", int'(score), m_score);
    chk("state", int'(state), m_st);
    chk("miss", int'(miss), m_miss);
    if (miss === 1'b1) miss_cnt++;
    if (int'(ball_x) > max_bx) max_bx = int'(ball_x);
  endtask

  // Called at a negedge; drives inputs, advances one edge, checks at the next negedge.
  task automatic step(input bit kr, input logic [4:0] kc, input bit ft);
    key_ready = kr; key_code = kc; frame_tick = ft;
    @(posedge clk);
    model_update(kr, kc, ft);
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input logic [4:0] kc);
    repeat (3) step(1'b1, kc, 1'b0);
    repeat (2) step(1'b0, kc, 1'b0);
  endtask

  // Press whose event edge coincides with a frame_tick: costs exactly one frame.
  task automatic press_f(input logic [4:0] kc);
    step(1'b1, kc, 1'b1);
    step(1'b1, kc, 1'b0);
    step(1'b0, kc, 1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) step(1'b0, 5'h00, 1'b1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; key_ready = 1'b0; key_code = 5'h00; frame_tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    tbl = '{
      '{5'h0c, 272, 304}, '{5'h0c, 256, 288}, '{5'h0c, 240, 272}, '{5'h0c, 224, 256},
      '{5'h0c, 208, 240}, '{5'h0c, 192, 224}, '{5'h0c, 176, 208}, '{5'h0c, 160, 192},
      '{5'h0c, 144, 176}, '{5'h0c, 128, 160}, '{5'h0c, 112, 144}, '{5'h0c,  96, 128},
      '{5'h0c,  80, 112}, '{5'h0c,  64,  96}, '{5'h0c,  48,  80}, '{5'h0c,  32,  64},
      '{5'h0c,  16,  48}, '{5'h0c,   0,  32}, '{5'h0c,   0,  32}, '{5'h0c,   0,  32},
      '{5'h01,   0,  32}, '{5'h0e,  16,  48}, '{5'h0e,  32,  64}, '{5'h0d,  32,  64}
    };
    miss_cnt = 0; max_bx = 0;

    // Reset state
    do_reset();
    chk("rst_paddle_x", int'(paddle_x), 288);
    chk("rst_ball_x", int'(ball_x), 320);
    chk("rst_ball_y", int'(ball_y), 435);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_miss", int'(miss), 0);

    // Paddle key table in IDLE
    foreach (tbl[i]) begin
      press(tbl[i].code);
      chk("tbl_paddle_x", int'(paddle_x), tbl[i].exp_pad);
      chk("tbl_ball_x", int'(ball_x), tbl[i].exp_bx);
      chk("tbl_state", int'(state), 0);
    end

    // Serve then 10 frames
    do_reset();
    press(5'h10);
    chk("serve_state", int'(state), 1);
    frames(10);
    chk("serve10_ball_x", int'(ball_x), 340);
    chk("serve10_ball_y", int'(ball_y), 415);

    // Frame tick on the serve edge is not consumed
    do_reset();
    step(1'b1, 5'h10, 1'b1);
    chk("srvft_state", int'(state), 1);
    chk("srvft_ball_x", int'(ball_x), 320);
    chk("srvft_ball_y", int'(ball_y), 435);
    step(1'b0, 5'h10, 1'b1);
    chk("srvft_next_x", int'(ball_x), 322);
    chk("srvft_next_y", int'(ball_y), 433);

    // Right wall, top wall, paddle hit (frame count k since serve)
    do_reset();
    press(5'h10);
    max_bx = 0;
    repeat (20) press_f(5'h0e);                 // k=20
    chk("right_clamp_paddle", int'(paddle_x), 576);
    frames(138);                                 // k=158
    chk("wall_ball_x", int'(ball_x), 635);
    frames(1);
    chk("wall_flip_x", int'(ball_x), 633);
    frames(57);                                  // k=216
    chk("top_ball_y", int'(ball_y), 4);
    chk("top_ball_x", int'(ball_x), 519);
    frames(1);
    chk("top_flip_y", int'(ball_y), 6);
    repeat (31) press_f(5'h0c);                 // k=248
    chk("hit_paddle_x", int'(paddle_x), 80);
    frames(183);                                 // k=431
    chk("prehit_ball_y", int'(ball_y), 434);
    chk("prehit_score", int'(score), 0);
    frames(1);
    chk("hit_ball_y", int'(ball_y), 436);
    chk("hit_ball_x", int'(ball_x), 87);
    chk("hit_score", int'(score), 1);
    chk("max_ball_x", max_bx, 635);
    frames(1);
    chk("hit_rise_y", int'(ball_y), 434);

    // Asynchronous reset between edges while in PLAY with score 1
    frames(3);
    key_ready = 1'b0; frame_tick = 1'b0;
    @(posedge clk);
    model_update(1'b0, 5'h00, 1'b0);
    #3 rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_paddle_x", int'(paddle_x), 288);
    chk("arst_ball_x", int'(ball_x), 320);
    chk("arst_ball_y", int'(ball_y), 435);
    chk("arst_lives", int'(lives), 3);
    chk("arst_score", int'(score), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_miss", int'(miss), 0);
    @(negedge clk);
    check_all();
    rstn = 1'b1;
    step(1'b0, 5'h00, 1'b1);

    // Three misses with the paddle parked at 0
    repeat (18) press(5'h0c);
    chk("park_paddle_x", int'(paddle_x), 0);
    miss_cnt = 0;
    for (int m = 0; m < 3; m++) begin
      press(5'h10);
      guard = 0;
      while (miss !== 1'b1 && guard < 2000) begin
        step(1'b0, 5'h00, 1'b1);
        guard++;
      end
      chk("miss_wait_ok", int'(guard < 2000), 1);
      chk("miss_lives", int'(lives), 2 - m);
      chk("miss_state", int'(state), (m == 2) ? 2 : 0);
      step(1'b0, 5'h00, 1'b1);
    end
    chk("miss_pulses", miss_cnt, 3);
    press(5'h0c);
    chk("over_left_paddle", int'(paddle_x), 0);
    chk("over_left_state", int'(state), 2);
    press(5'h10);
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);
    chk("restart_paddle", int'(paddle_x), 288);
    chk("restart_state", int'(state), 0);

    // Random key levels and frame ticks against the model
    do_reset();
    rnd_kr = 1'b0; rnd_kc = 5'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        rnd_kr = !rnd_kr;
        if (rnd_kr) begin
          case ($urandom_range(0, 5))
            0, 1:    rnd_kc = 5'h0c;
            2, 3:    rnd_kc = 5'h0e;
            4:       rnd_kc = 5'h10;
            default: rnd_kc = 5'($urandom);
          endcase
        end
      end
      step(rnd_kr, rnd_kc, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
